// File: rtl/fpga_calculator_pkg.sv
// Shared types, segment encodings and the binary-to-BCD helper for the
// two-digit BCD calculator.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  typedef enum logic {
    MODE_OPERAND = 1'b0,
    MODE_RESULT  = 1'b1
  } mode_t;

  // Active-low segments, bit 0 = a ... bit 6 = g, bit 7 = dp (kept off).
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [0:9][7:0] SEG_TABLE = {
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  // Codes above 9 carried to the decoder.
  localparam logic [3:0] CODE_MINUS = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  // Double-dabble; 9801 is the largest value that ever reaches it.
  function automatic logic [15:0] bin2bcd(input logic [13:0] bin);
    logic [15:0] bcd;
    bcd = '0;
    for (int i = 13; i >= 0; i--) begin
      for (int j = 0; j < 4; j++) begin
        if (bcd[4*j +: 4] >= 4'd5) bcd[4*j +: 4] = bcd[4*j +: 4] + 4'd3;
      end
      bcd = {bcd[14:0], bin[i]};
    end
    return bcd;
  endfunction

endpackage

// File: rtl/fpga_calculator_if.sv
// Board-facing bus of the calculator: raw buttons in, seven-segment scan out,
// plus the display mode for observation.
interface calc_if;
  import calc_pkg::*;

  // Buttons are raw levels with no valid/ready handshake: only a synchronized
  // rising edge acts, and the display outputs are always valid.
  logic [3:0] B1;
  logic [3:0] B2;
  logic       push;
  logic [7:0] seg;
  logic [3:0] Anode_Activate;
  mode_t      mode;

  modport master (output B1, output B2, output push,
                  input seg, input Anode_Activate, input mode);
  modport slave  (input B1, input B2, input push,
                  output seg, output Anode_Activate, output mode);
endinterface

// File: rtl/fpga_calculator_seg7_decoder.sv
// Maps a digit code (0-9, minus, blank) to active-low seven-segment levels.
module seg7_decoder
  import calc_pkg::*;
(
  input  logic [3:0] code,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (code <= 4'd9) seg = SEG_TABLE[code];
    else if (code == CODE_MINUS) seg = SEG_MINUS;
  end

endmodule

// File: rtl/fpga_calculator.sv
// Two-digit BCD calculator driving a 4-digit multiplexed display.
// Optional DEBOUNCE_EN adds a per-button stability filter after the synchronizer.
module fpga_calculator
  import calc_pkg::*;
#(
  parameter int REFRESH_BITS    = 18,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input logic   clk_in,
  input logic   rst,
  calc_if.slave bus
);

  localparam int NB = 9;  // {push, B2[3:0], B1[3:0]}

  logic [NB-1:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [NB-1:0] level, btn_edge;

  always_comb begin
    sync1_d  = {bus.push, bus.B2, bus.B1};
    sync2_d  = sync1_q;
    prev_d   = level;
    btn_edge = level & ~prev_q;
  end

`ifdef DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] db_cnt_q [NB];
  logic [CW-1:0] db_cnt_d [NB];
  logic [NB-1:0] stable_q, stable_d;

  // A new level is accepted only after it differs from the accepted one for
  // DEBOUNCE_CYCLES consecutive cycles; any bounce back restarts the count.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NB; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) stable_d[i] = sync2_q[i];
        else db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      stable_q <= '0;
      for (int i = 0; i < NB; i++) db_cnt_q[i] <= '0;
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < NB; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  assign level = stable_q;
`else
  assign level = sync2_q;
`endif

  logic b1_any, op_go, push_edge;
  assign b1_any    = |btn_edge[3:0];
  assign op_go     = !b1_any && (|btn_edge[7:4]);
  assign push_edge = btn_edge[8];

  logic [3:0] dig_q [4];
  logic [3:0] dig_d [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      dig_d[i] = dig_q[i];
      if (btn_edge[i]) dig_d[i] = (dig_q[i] == 4'd9) ? 4'd0 : dig_q[i] + 4'd1;
    end
  end

  logic [6:0] op_a, op_b;
  assign op_a = 7'(dig_q[0]) * 7'd10 + 7'(dig_q[1]);
  assign op_b = 7'(dig_q[2]) * 7'd10 + 7'(dig_q[3]);

  op_t         op_sel;
  logic [13:0] alu_mag;
  logic        alu_neg, alu_err;

  always_comb begin
    op_sel  = OP_DIV;
    if (btn_edge[4])      op_sel = OP_ADD;
    else if (btn_edge[5]) op_sel = OP_SUB;
    else if (btn_edge[6]) op_sel = OP_MUL;
    alu_mag = '0;
    alu_neg = 1'b0;
    alu_err = 1'b0;
    case (op_sel)
      OP_ADD: alu_mag = 14'(op_a) + 14'(op_b);
      OP_SUB: begin
        // Stored as sign + magnitude so the display needs no two's complement.
        if (op_a >= op_b) alu_mag = 14'(op_a - op_b);
        else begin
          alu_neg = 1'b1;
          alu_mag = 14'(op_b - op_a);
        end
      end
      OP_MUL: alu_mag = 14'(op_a) * 14'(op_b);
      default: begin
        if (op_b == 7'd0) alu_err = 1'b1;
        else alu_mag = 14'(op_a / op_b);
      end
    endcase
  end

  logic [13:0] res_mag_q, res_mag_d;
  logic        res_neg_q, res_neg_d, res_err_q, res_err_d;

  always_comb begin
    res_mag_d = res_mag_q;
    res_neg_d = res_neg_q;
    res_err_d = res_err_q;
    if (op_go) begin
      res_mag_d = alu_mag;
      res_neg_d = alu_neg;
      res_err_d = alu_err;
    end
  end

  mode_t mode_q, mode_d;

  always_comb begin
    mode_d = mode_q;
    if (b1_any)               mode_d = MODE_OPERAND;
    else if (|btn_edge[7:4])  mode_d = MODE_RESULT;
    else if (push_edge)       mode_d = MODE_OPERAND;
  end

  logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
  logic [1:0]              sel;
  logic [15:0]             bcd;
  logic [3:0]              digit_code;

  assign refresh_d = refresh_q + 1'b1;
  assign sel       = refresh_q[REFRESH_BITS-1 -: 2];
  assign bcd       = bin2bcd(res_mag_q);

  always_comb begin
    digit_code = CODE_BLANK;
    if (mode_q == MODE_OPERAND)        digit_code = dig_q[sel];
    else if (res_err_q)                digit_code = CODE_MINUS;
    else if (res_neg_q && sel == 2'd0) digit_code = CODE_MINUS;
    else                               digit_code = bcd[4*(3 - 32'(sel)) +: 4];
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      for (int i = 0; i < 4; i++) dig_q[i] <= '0;
      res_mag_q <= '0;
      res_neg_q <= 1'b0;
      res_err_q <= 1'b0;
      mode_q    <= MODE_OPERAND;
      refresh_q <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      for (int i = 0; i < 4; i++) dig_q[i] <= dig_d[i];
      res_mag_q <= res_mag_d;
      res_neg_q <= res_neg_d;
      res_err_q <= res_err_d;
      mode_q    <= mode_d;
      refresh_q <= refresh_d;
    end
  end

  seg7_decoder u_dec (
    .code (digit_code),
    .seg  (bus.seg)
  );

  assign bus.Anode_Activate = ~(4'b1000 >> sel);
  assign bus.mode           = mode_q;

endmodule

// File: tb/tb_fpga_calculator.sv
// Directed bench for fpga_calculator: digit editing, all four operations,
// negative and divide-by-zero display, simultaneous edges and reset.
module tb_fpga_calculator;
  import calc_pkg::*;

  logic       clk_in = 1'b0;
  logic       rst;
  logic [8:0] btns;  // {push, B2[3:0], B1[3:0]}
  int         checks = 0;
  int         passed = 0;

  calc_if bus ();

  assign bus.B1   = btns[3:0];
  assign bus.B2   = btns[7:4];
  assign bus.push = btns[8];

  fpga_calculator #(.REFRESH_BITS(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  always #10 clk_in = ~clk_in;

  function automatic logic [7:0] exp_seg(input logic [3:0] c);
    case (c)
      4'd0: return 8'hC0;
      4'd1: return 8'hF9;
      4'd2: return 8'hA4;
      4'd3: return 8'hB0;
      4'd4: return 8'h99;
      4'd5: return 8'h92;
      4'd6: return 8'h82;
      4'd7: return 8'hF8;
      4'd8: return 8'h80;
      4'd9: return 8'h90;
      4'hA: return 8'hBF;
      default: return 8'hFF;
    endcase
  endfunction

  // Digits given left to right as hex nibbles; nibble A means '-'.
  task automatic check_display(input logic [15:0] exp_digits, input string name);
    logic [7:0] got [4];
    logic [3:0] c;
    int         bad;
    bad = 0;
    for (int i = 0; i < 4; i++) got[i] = 8'hxx;
    repeat (16) begin
      @(negedge clk_in);
      case (bus.Anode_Activate)
        4'b0111: got[0] = bus.seg;
        4'b1011: got[1] = bus.seg;
        4'b1101: got[2] = bus.seg;
        4'b1110: got[3] = bus.seg;
        default: bad++;
      endcase
    end
    checks++;
    if (bad !== 0) $display("FAIL %s anode_onehot: %0d bad samples, required 0", name, bad);
    else passed++;
    for (int d = 0; d < 4; d++) begin
      c = exp_digits[15-4*d -: 4];
      checks++;
      if (got[d] !== exp_seg(c))
        $display("FAIL %s digit%0d: seg=%h, required %h", name, d, got[d], exp_seg(c));
      else passed++;
    end
  endtask

  task automatic check_mode(input mode_t m, input string name);
    checks++;
    if (bus.mode !== m) $display("FAIL %s mode: got %0d, required %0d", name, bus.mode, m);
    else passed++;
  endtask

  task automatic press_vec(input logic [8:0] v);
    @(negedge clk_in);
    btns = v;
    repeat (2) @(negedge clk_in);
    btns = '0;
    repeat (4) @(negedge clk_in);
  endtask

  task automatic press(input int idx, input int n);
    logic [8:0] v;
    v = '0;
    v[idx] = 1'b1;
    repeat (n) press_vec(v);
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    btns = '0;
    repeat (3) @(negedge clk_in);
    checks++;
    if (bus.Anode_Activate !== 4'b0111)
      $display("FAIL reset anode: got %b, required 0111", bus.Anode_Activate);
    else passed++;
    checks++;
    if (bus.seg !== 8'hC0) $display("FAIL reset seg: got %h, required c0", bus.seg);
    else passed++;
    check_mode(MODE_OPERAND, "reset");
    rst = 1'b0;
    check_display(16'h0000, "after_reset");
  endtask

  task automatic test_digits();
    for (int b = 0; b < 4; b++) press(b, 9);
    check_display(16'h9999, "digits_9999");
    check_mode(MODE_OPERAND, "digits_9999");
  endtask

  task automatic test_ops_99();
    press(6, 1); check_display(16'h9801, "mul_99_99");
    check_mode(MODE_RESULT, "mul_99_99");
    press(4, 1); check_display(16'h0198, "add_99_99");
    press(5, 1); check_display(16'h0000, "sub_99_99");
    press(7, 1); check_display(16'h0001, "div_99_99");
    press(8, 1); check_display(16'h9999, "push_9999");
    check_mode(MODE_OPERAND, "push_9999");
  endtask

  task automatic test_ops_9998();
    press(3, 9); check_display(16'h9998, "digits_9998");
    press(5, 1); check_display(16'h0001, "sub_99_98");
    press(7, 1); check_display(16'h0001, "div_99_98");
    press(8, 1); check_display(16'h9998, "push_9998");
  endtask

  task automatic test_negative();
    press(0, 4);
    press(1, 3); check_display(16'h3298, "digits_3298");
    press(5, 1); check_display(16'hA066, "sub_negative");
    press(7, 1); check_display(16'h0000, "div_32_98");
    press(6, 1); check_display(16'h3136, "mul_32_98");
  endtask

  task automatic test_div_zero();
    press(2, 2);
    press(3, 2); check_display(16'h3210, "digits_3210");
    press(7, 1); check_display(16'h0003, "div_32_10");
    press(2, 9); check_display(16'h3200, "digits_3200");
    press(7, 1); check_display(16'hAAAA, "div_by_zero");
    check_mode(MODE_RESULT, "div_by_zero");
  endtask

  task automatic test_simultaneous();
    press_vec(9'b0_0001_0001);
    check_display(16'h4200, "b1_beats_b2");
    check_mode(MODE_OPERAND, "b1_beats_b2");
    press_vec(9'b1_0001_0000);
    check_display(16'h0042, "op_beats_push");
    check_mode(MODE_RESULT, "op_beats_push");
    press_vec(9'b0_1100_0000);
    check_display(16'h0000, "mul_over_div");
    press_vec(9'b0_0110_0000);
    check_display(16'h0042, "sub_over_mul");
  endtask

  task automatic test_hold();
    @(negedge clk_in);
    btns = 9'b0_0000_0010;
    repeat (12) @(negedge clk_in);
    btns = '0;
    repeat (4) @(negedge clk_in);
    check_display(16'h4300, "held_button");
    check_mode(MODE_OPERAND, "held_button");
  endtask

  task automatic test_reset_midscan();
    repeat (5) @(negedge clk_in);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (bus.Anode_Activate !== 4'b0111)
      $display("FAIL midscan_reset anode: got %b, required 0111", bus.Anode_Activate);
    else passed++;
    checks++;
    if (bus.seg !== 8'hC0) $display("FAIL midscan_reset seg: got %h, required c0", bus.seg);
    else passed++;
    @(negedge clk_in);
    rst = 1'b0;
    check_display(16'h0000, "after_midscan_reset");
  endtask

  initial begin
    test_reset();
    test_digits();
    test_ops_99();
    test_ops_9998();
    test_negative();
    test_div_zero();
    test_simultaneous();
    test_hold();
    test_reset_midscan();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fpga_calculator.md
# fpga_calculator

Two-digit BCD calculator top for the board's 4-digit seven-segment display. Four buttons edit the four operand digits (operand A = two left digits, operand B = two right digits). Four buttons select add/subtract/multiply/divide, and the result is shown on the display. A recall button returns the display to the operands.

## Interface
Parameters:
- REFRESH_BITS, 18: width of the display refresh counter; its top 2 bits select the active digit.
- DEBOUNCE_CYCLES, 65536: stable-input cycles required per button; used only with DEBOUNCE_EN.

Ports:
- clk_in  in  1  system clock; the only clock, all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- B1  in  4  digit buttons: B1[0] A tens, B1[1] A units, B1[2] B tens, B1[3] B units.
- B2  in  4  operation buttons: B2[0] add, B2[1] subtract, B2[2] multiply, B2[3] divide.
- push  in  1  recall: display the operands again.
- seg  out  8  active-low segments: seg[0]=a … seg[6]=g, seg[7]=dp (dp always off, 1).
- Anode_Activate  out  4  active-low digit enables; Anode_Activate[3] = leftmost digit (digit 0), Anode_Activate[0] = rightmost (digit 3).

## Operation
- Every button passes through a 2-flop synchronizer and a rising-edge detector. Only edges act; held buttons do nothing more.
- Digit edge on B1[i]: digit i increments 0→9, then 9 wraps to 0. The display switches to OPERAND mode.
- Operation edge on B2: the result is computed from the current A and B (0..99 each) and latched. The display switches to RESULT mode.
  - Add: 0..198.
  - Subtract: A−B, −99..99.
  - Multiply: 0..9801, 14-bit.
  - Divide: floor(A/B); B=0 sets an error flag.
- push edge: display switches to OPERAND mode; operands and result are unchanged.
- Modes: OPERAND and RESULT. Transitions happen only on the edges above.
- Display format:
  - OPERAND mode: the four digits A1 A0 B1 B0, no blanking.
  - RESULT mode, non-negative: 4-digit zero-padded decimal, e.g. 0198.
  - RESULT mode, negative: leftmost digit shows '-' (segment g only) and the other three show the magnitude, e.g. −66 → "-066".
  - Divide by zero: all four digits show '-'.
- Simultaneous edges in one cycle:
  - All B1 edges apply independently. Any B1 edge forces OPERAND mode, and the operation edges in that cycle are ignored.
  - Several B2 edges: priority add > subtract > multiply > divide.
  - B2 together with push: the operation wins.
- Multiplexing: a free-running REFRESH_BITS counter; top 2 bits = 0..3 selects digit 0..3. Exactly one anode is low at any time.

## Timing
- Reset (async assert, sync release):
  - Digits = 0, mode OPERAND, result 0, error flag clear.
  - Refresh counter 0, synchronizers and edge detectors cleared.
  - Outputs: Anode_Activate=4'b0111, seg=8'hC0 ('0').
- Latency: a button rising at the input updates its register on the 3rd clk_in rising edge (2 sync + edge detect). The outputs reflect the change in the same cycle when that digit is being scanned.
- Result is registered in the cycle the edge is detected; the arithmetic is single-cycle combinational.
- A pulse of 2 or more clock periods is always captured. Pulses shorter than 1 period may be missed.
- Refresh period per digit = 2^(REFRESH_BITS−2) cycles.

## Configuration
- DEBOUNCE_EN defined: each synchronized button must stay stable for DEBOUNCE_CYCLES cycles before its level is accepted, and the edge detector uses the accepted level.
- Without DEBOUNCE_EN: synchronizer + edge detector only, matching the latency above.

## Structure
- Package calc_pkg:
  - op_t enum (OP_ADD, OP_SUB, OP_MUL, OP_DIV).
  - mode_t enum (MODE_OPERAND, MODE_RESULT).
  - Segment constants SEG_MINUS=8'hBF and SEG_BLANK=8'hFF.
  - 0–9 segment table.
- One sub-module, seg7_decoder: maps a 4-bit code (0–9, minus, blank) to seg. The top contains the synchronizers, digit registers, ALU, binary-to-BCD conversion and the scan mux.

## Test plan
Use REFRESH_BITS=4 and a 20 ns clk_in period.
- Reset, then 9 pulses on each B1 bit → OPERAND display 9 9 9 9 across the scan.
- With 99/99:
  - B2[2] → 9801.
  - B2[0] → 0198.
  - B2[1] → 0000.
  - B2[3] → 0001.
  - push → 9999.
- 9 more pulses on B1[3] → 9998; B2[1] → 0001; B2[3] → 0001; push → 9998.
- 4 pulses B1[0], 3 pulses B1[1] → 3298.
  - B2[1] → "-066" (leftmost anode shows 8'hBF).
  - B2[3] → 0000.
  - B2[2] → 3136.
- 2 pulses each on B1[2] and B1[3] → 3210; B2[3] → 0003. Then set B to 00 and press B2[3] → "----".
- Corner cases:
  - B1[0] and B2[0] in the same cycle → digit increments, OPERAND mode.
  - rst asserted mid-scan → immediate 4'b0111 / 8'hC0.
